// File: rtl/tr_step_gen.sv
// Stepper step/direction pulse generator: SETUP (dir settle), HIGH, LOW phases from one down-counting timer.
// Latency: the first step rises DIR_SETUP+1 cycles after enable is sampled high in IDLE; all outputs registered.
// Backpressure: none; enable is a level request, and a started HIGH+LOW pair always completes except on rst.
// Ports: clk, rst (sync, active-high), enable, dir_in, half_period[WIDTH], count_clr ->
//        step, dir_out, count_N[2*WIDTH] (saturating pulse count), busy (state != IDLE).
module tr_step_gen #(
  parameter int WIDTH     = 16,
  parameter int DIR_SETUP = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               dir_in,
  input  logic [WIDTH-1:0]   half_period,
  input  logic               count_clr,
  output logic               step,
  output logic               dir_out,
  output logic [2*WIDTH-1:0] count_N,
  output logic               busy
);

  // Timer must hold both a half period and the setup delay (up to 255).
  localparam int TW = (WIDTH > 8) ? WIDTH : 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } state_t;

  state_t             state, state_d;
  logic [TW-1:0]      timer, timer_d;
  logic [WIDTH-1:0]   hp_q, hp_d;
  logic               step_d;
  logic               dir_d;
  logic               inc;
  logic [WIDTH-1:0]   hp_eff;
  logic [TW-1:0]      hp_eff_tw;
  logic [TW-1:0]      hp_q_tw;
  logic [TW-1:0]      setup_tw;
  logic               timer_last;
  logic [2*WIDTH-1:0] count_d;

  // A zero half period would mean a zero-length phase; run it as one cycle.
  assign hp_eff     = (half_period == '0) ? WIDTH'(1) : half_period;
  assign hp_eff_tw  = TW'(hp_eff);
  assign hp_q_tw    = TW'(hp_q);
  assign setup_tw   = TW'(DIR_SETUP);
  // Timer holds the number of cycles left in the current phase, including this one.
  assign timer_last = (timer <= TW'(1));

  always_comb begin
    state_d = state;
    timer_d = timer;
    hp_d    = hp_q;
    step_d  = 1'b0;
    dir_d   = dir_out;
    inc     = 1'b0;
    case (state)
      IDLE: begin
        timer_d = '0;
        if (enable) begin
          state_d = SETUP;
          dir_d   = dir_in;
          timer_d = setup_tw;
        end
      end
      SETUP: begin
        // enable is not looked at here: once setup starts, one pulse follows.
        if (timer_last) begin
          state_d = HIGH;
          timer_d = hp_eff_tw;
          hp_d    = hp_eff;
          step_d  = 1'b1;
          inc     = 1'b1;
        end else begin
          timer_d = timer - TW'(1);
        end
      end
      HIGH: begin
        if (timer_last) begin
          state_d = LOW;
          timer_d = hp_q_tw;       // LOW reuses the half period latched at HIGH entry
        end else begin
          timer_d = timer - TW'(1);
          step_d  = 1'b1;
        end
      end
      LOW: begin
        if (timer_last) begin
          if (!enable) begin
            state_d = IDLE;
            timer_d = '0;
          end else if (dir_in != dir_out) begin
            // Direction only ever changes here or from IDLE, with step low.
            state_d = SETUP;
            dir_d   = dir_in;
            timer_d = setup_tw;
          end else begin
            state_d = HIGH;
            timer_d = hp_eff_tw;
            hp_d    = hp_eff;
            step_d  = 1'b1;
            inc     = 1'b1;
          end
        end else begin
          timer_d = timer - TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Clear wins over hold but not over a simultaneous increment, which yields 1.
  always_comb begin
    count_d = count_N;
    if (count_clr) begin
      count_d = inc ? (2*WIDTH)'(1) : '0;
    end else if (inc && (count_N != '1)) begin
      count_d = count_N + (2*WIDTH)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      timer   <= '0;
      hp_q    <= '0;
      step    <= 1'b0;
      dir_out <= 1'b0;
      count_N <= '0;
      busy    <= 1'b0;
    end else begin
      state   <= state_d;
      timer   <= timer_d;
      hp_q    <= hp_d;
      step    <= step_d;
      dir_out <= dir_d;
      count_N <= count_d;
      busy    <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_tr_step_gen.sv
module tb_tr_step_gen;

  localparam int W  = 4;
  localparam int DS = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           enable;
  logic           dir_in;
  logic [W-1:0]   half_period;
  logic           count_clr;
  logic           step;
  logic           dir_out;
  logic [2*W-1:0] count_N;
  logic           busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tr_step_gen #(.WIDTH(W), .DIR_SETUP(DS)) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .dir_in(dir_in),
    .half_period(half_period),
    .count_clr(count_clr),
    .step(step),
    .dir_out(dir_out),
    .count_N(count_N),
    .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: timed out waiting at %0t", nm, $time);
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    logic       r;
    logic       en;
    logic       d;
    logic [3:0] hp;
    logic       clr;
    logic       es;
    logic       ed;
    logic       eb;
    logic [7:0] ec;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic r, input logic en, input logic d, input logic [3:0] hp,
                     input logic clr, input logic es, input logic ed, input logic eb,
                     input logic [7:0] ec);
    vec_t v;
    v.r = r; v.en = en; v.d = d; v.hp = hp; v.clr = clr;
    v.es = es; v.ed = ed; v.eb = eb; v.ec = ec;
    tbl.push_back(v);
  endtask

  // ---------------- reference model ----------------
  // Output plan as a queue of per-cycle (step, counts-a-pulse) entries,
  // refilled whenever the previous plan runs out.
  typedef struct {
    logic s;
    logic inc;
  } plan_t;
  plan_t      mq[$];
  int         m_kind;  // 0 idle, 1 pulse due next, 2 decide after pulse
  logic       m_step;
  logic       m_dir;
  logic       m_busy;
  logic [7:0] m_cnt;

  task automatic push_setup();
    plan_t p;
    p.s = 1'b0; p.inc = 1'b0;
    for (int i = 0; i < DS; i++) mq.push_back(p);
  endtask

  task automatic push_pulse();
    plan_t p;
    int hp;
    hp = (half_period == 0) ? 1 : int'(half_period);
    for (int i = 0; i < hp; i++) begin
      p.s = 1'b1; p.inc = (i == 0);
      mq.push_back(p);
    end
    for (int i = 0; i < hp; i++) begin
      p.s = 1'b0; p.inc = 1'b0;
      mq.push_back(p);
    end
  endtask

  task automatic model_edge();
    plan_t e;
    logic  inc;
    inc = 1'b0;
    if (rst) begin
      mq.delete();
      m_kind = 0; m_step = 1'b0; m_dir = 1'b0; m_busy = 1'b0; m_cnt = 8'd0;
    end else begin
      if (mq.size() == 0) begin
        if (m_kind == 0) begin
          if (enable) begin
            m_dir = dir_in; push_setup(); m_kind = 1;
          end
        end else if (m_kind == 1) begin
          push_pulse(); m_kind = 2;
        end else begin
          if (!enable) begin
            m_kind = 0;
          end else if (dir_in != m_dir) begin
            m_dir = dir_in; push_setup(); m_kind = 1;
          end else begin
            push_pulse();
          end
        end
      end
      if (mq.size() != 0) begin
        e = mq.pop_front();
        m_step = e.s; inc = e.inc; m_busy = 1'b1;
      end else begin
        m_step = 1'b0; m_busy = 1'b0;
      end
      if (count_clr) m_cnt = inc ? 8'd1 : 8'd0;
      else if (inc && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    end
  endtask

  initial begin
    bit found;
    rst = 1'b1; enable = 1'b0; dir_in = 1'b0; half_period = '0; count_clr = 1'b0;

    // Start then stop mid-pulse (hp=3): setup 4, high 3, low 3, then idle.
    add(1,0,0,3,0, 0,0,0,0);
    for (int i = 0; i < 4; i++) add(0,1,1,3,0, 0,1,1,0);
    add(0,1,1,3,0, 1,1,1,1);
    add(0,0,1,3,0, 1,1,1,1);
    add(0,0,1,3,0, 1,1,1,1);
    for (int i = 0; i < 3; i++) add(0,0,1,3,0, 0,1,1,1);
    add(0,0,1,3,0, 0,1,0,1);
    add(0,0,1,3,0, 0,1,0,1);
    // Direction flip: dir_in drops during the first HIGH.
    add(1,0,0,3,0, 0,0,0,0);
    for (int i = 0; i < 4; i++) add(0,1,1,3,0, 0,1,1,0);
    add(0,1,1,3,0, 1,1,1,1);
    add(0,1,1,3,0, 1,1,1,1);
    add(0,1,0,3,0, 1,1,1,1);
    for (int i = 0; i < 3; i++) add(0,1,0,3,0, 0,1,1,1);
    for (int i = 0; i < 4; i++) add(0,1,0,3,0, 0,0,1,1);
    add(0,1,0,3,0, 1,0,1,2);
    // Reset during HIGH truncates the pulse.
    add(1,1,0,3,0, 0,0,0,0);

    foreach (tbl[i]) begin
      rst = tbl[i].r; enable = tbl[i].en; dir_in = tbl[i].d;
      half_period = tbl[i].hp; count_clr = tbl[i].clr;
      tick();
      chk($sformatf("vec%0d_step", i), 32'(step),    32'(tbl[i].es));
      chk($sformatf("vec%0d_dir", i),  32'(dir_out), 32'(tbl[i].ed));
      chk($sformatf("vec%0d_busy", i), 32'(busy),    32'(tbl[i].eb));
      chk($sformatf("vec%0d_cnt", i),  32'(count_N), 32'(tbl[i].ec));
    end

    // Reset while HIGH with count 7.
    rst = 1'b1; enable = 1'b0; tick();
    rst = 1'b0; half_period = '0; enable = 1'b1; dir_in = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (count_N == 8'd7 && step) found = 1'b1;
    end
    if (!found) timeout("reach_cnt7_high");
    rst = 1'b1; tick(); rst = 1'b0; enable = 1'b0;
    chk("rst_step", 32'(step), 0);
    chk("rst_cnt",  32'(count_N), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_dir",  32'(dir_out), 0);

    // half_period=0 alternates 1/1, then a mid-HIGH change only affects the next HIGH.
    rst = 1'b1; tick(); rst = 1'b0;
    half_period = '0; enable = 1'b1; dir_in = 1'b1;
    repeat (5) tick();
    chk("hp0_first_rise", 32'(step), 1);
    for (int j = 1; j <= 7; j++) begin
      tick();
      chk($sformatf("hp0_alt%0d", j), 32'(step), 32'(j % 2 == 0));
    end
    half_period = W'(2);
    tick(); chk("hp2_rise", 32'(step), 1);
    half_period = W'(5);
    tick(); chk("hp2_high2", 32'(step), 1);
    tick(); chk("hp2_low1", 32'(step), 0);
    tick(); chk("hp2_low2", 32'(step), 0);
    for (int j = 0; j < 5; j++) begin
      tick(); chk($sformatf("hp5_high%0d", j), 32'(step), 1);
    end
    tick(); chk("hp5_low", 32'(step), 0);

    // Saturation and clear.
    rst = 1'b1; tick(); rst = 1'b0;
    half_period = '0; enable = 1'b1; dir_in = 1'b1;
    repeat (620) tick();
    chk("sat_cnt", 32'(count_N), 255);
    found = 1'b0;
    for (int i = 0; i < 4 && !found; i++) begin
      if (!step) found = 1'b1;
      else tick();
    end
    if (!found) timeout("sat_find_low");
    count_clr = 1'b1; tick(); count_clr = 1'b0;
    chk("clr_inc_cnt",  32'(count_N), 1);
    chk("clr_inc_step", 32'(step), 1);
    tick(); tick();
    chk("after_clr_cnt", 32'(count_N), 2);
    count_clr = 1'b1; tick(); count_clr = 1'b0;
    chk("clr_only_cnt", 32'(count_N), 0);

    // Randomized run against the plan-queue model.
    enable = 1'b0; dir_in = 1'b0; half_period = W'(2);
    for (int c = 0; c < 3000; c++) begin
      rst = (c == 0) || ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 19) == 0) enable = ~enable;
      if ($urandom_range(0, 14) == 0) dir_in = ~dir_in;
      if ($urandom_range(0, 9) == 0) half_period = W'($urandom_range(0, 4));
      count_clr = ($urandom_range(0, 59) == 0);
      model_edge();
      tick();
      chk("rnd_step", 32'(step),    32'(m_step));
      chk("rnd_dir",  32'(dir_out), 32'(m_dir));
      chk("rnd_busy", 32'(busy),    32'(m_busy));
      chk("rnd_cnt",  32'(count_N), 32'(m_cnt));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tr_step_gen.md
TR_STEP_GEN -- requirements
Module: tr_step_gen

Parameters
REQ-001 SHALL provide parameter WIDTH, default 16; half-period input width; count_N width is 2*WIDTH.
REQ-002 SHALL provide parameter DIR_SETUP, default 4; clk cycles dir_out is held stable before the first step edge, legal range 1..255.

Interface
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 enable  input  1  stepper-drive enable from the manual/auto tuner FSM; level-sensitive.
REQ-006 dir_in  input  1  requested motor direction.
REQ-007 half_period  input  WIDTH  step high time and step low time, in clk cycles.
REQ-008 count_clr  input  1  synchronous clear of count_N.
REQ-009 step  output  1  step pulse to the motor driver; registered.
REQ-010 dir_out  output  1  direction to the motor driver; registered.
REQ-011 count_N  output  2*WIDTH  number of step pulses generated since the last reset or clear; registered.
REQ-012 busy  output  1  high whenever state is not IDLE; registered.

Function
REQ-013 FSM states SHALL be IDLE, SETUP, HIGH and LOW, with a single down-counting phase timer.
REQ-014 IDLE: step=0; enable=1 sampled at edge t -> state SETUP, dir_out<=dir_in, busy=1, all from t+1; timer loaded with DIR_SETUP.
REQ-015 SETUP: step=0, duration exactly DIR_SETUP cycles; then HIGH; enable is ignored in SETUP.
REQ-016 HIGH: step=1 for exactly hp cycles, where hp is half_period latched on HIGH entry; then LOW.
REQ-017 LOW: step=0 for exactly hp cycles (same latched hp), then the exit is chosen from enable and dir_in sampled on the last LOW cycle.
REQ-018 LOW exit with enable=0 SHALL go to IDLE.
REQ-019 LOW exit with enable=1 and dir_in!=dir_out SHALL load dir_out<=dir_in and go to SETUP.
REQ-020 LOW exit with enable=1 and dir_in==dir_out SHALL go to HIGH.
REQ-021 A started pulse SHALL never be truncated: deasserting enable in SETUP, HIGH or LOW still completes the current HIGH+LOW pair.
REQ-022 If enable drops during SETUP, the FSM SHALL still complete one pulse.
REQ-023 half_period=0 SHALL be treated as 1.
REQ-024 Changes on half_period SHALL take effect only at the next HIGH entry.
REQ-025 count_N SHALL increment by 1 on the same edge step rises (HIGH entry).
REQ-026 count_N SHALL saturate at all-ones with no wrap.
REQ-027 count_clr SHALL set count_N to 0; count_clr coincident with an increment SHALL yield 1.
REQ-028 dir_out SHALL change only in IDLE->SETUP or LOW->SETUP transitions, never while step=1.
REQ-029 Step rising-edge latency from enable sampled high in IDLE SHALL be DIR_SETUP+1 cycles.
REQ-030 Step period SHALL be 2*hp cycles when direction is constant.
REQ-031 busy SHALL deassert on the cycle state returns to IDLE.

Reset
REQ-032 rst=1 SHALL force, on the next edge from any state: state=IDLE, step=0, dir_out=0, count_N=0, busy=0, timer=0.
REQ-033 rst SHALL have priority over enable and count_clr.
REQ-034 rst mid-pulse SHALL truncate step to 0 on the next edge; this is the only case where a pulse is truncated.

Verification
REQ-035 Reset: run in HIGH with count_N=7, pulse rst for 1 cycle -> next cycle step=0, count_N=0, busy=0, dir_out=0.
REQ-036 Start: DIR_SETUP=4, half_period=3, dir_in=1, enable high sampled at edge 10 -> dir_out=1 and busy=1 from 11; step=1 on 15-17; step=0 on 18-20; count_N=1 from 15; step rises again at 21.
REQ-037 Stop mid-pulse: as REQ-036, enable=0 at cycle 16 -> step stays high to 17, low 18-20, busy=0 from 21, count_N remains 1.
REQ-038 Direction flip: running with dir_in=1, set dir_in=0 at cycle 16 -> dir_out=0 at 21, step low on 21-24, next step rise at 25, count_N=2 at 25.
REQ-039 Saturation/clear: WIDTH=4 (8-bit count), run 300 pulses -> count_N=255; count_clr on a HIGH-entry edge -> count_N=1.
REQ-040 Corner: half_period=0 -> step alternates 1 cycle high / 1 cycle low; half_period changed to 5 mid-HIGH -> current phase keeps the old value, next HIGH lasts 5 cycles.
